// File: rtl/reg_fwd_ctrl.sv
// Pipeline control beside the register file: tracks EX/WB destinations, picks the forwarding
// source for each ID read port, drives the WB-slot write strobes and stalls on EX hazards or mul/div.
module reg_fwd_ctrl #(
   parameter int REG_NUM_WIDTH     = 4,
   parameter int REG_FORWARD_WIDTH = 2,
   parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = 2'b00,
   parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB       = 2'b01,
   parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0       = 2'b10,
   parameter int MULTI_CYCLES      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [REG_NUM_WIDTH-1:0]     id_rn_1,
   input  logic [REG_NUM_WIDTH-1:0]     id_rn_2,
   input  logic                         id_use_1,
   input  logic                         id_use_2,
   input  logic                         id_valid,
   input  logic                         id_wr,
   input  logic [REG_NUM_WIDTH-1:0]     id_wrn,
   input  logic                         id_wr0,
   input  logic                         id_multi,
   input  logic                         flush,
   output logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
   output logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
   output logic                         stall,
   output logic                         wr,
   output logic [REG_NUM_WIDTH-1:0]     wrn,
   output logic                         wr0
);

   localparam int CNT_W = $clog2(MULTI_CYCLES + 1);

   logic                     ex_valid_q, ex_valid_d;
   logic                     ex_wr_q, ex_wr_d;
   logic [REG_NUM_WIDTH-1:0] ex_wrn_q, ex_wrn_d;
   logic                     ex_wr0_q, ex_wr0_d;
   logic                     wb_valid_q, wb_valid_d;
   logic                     wb_wr_q, wb_wr_d;
   logic [REG_NUM_WIDTH-1:0] wb_wrn_q, wb_wrn_d;
   logic                     wb_wr0_q, wb_wr0_d;
   logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;

   logic busy, haz_1, haz_2;

   assign wr  = wb_valid_q & wb_wr_q;
   assign wrn = wb_wrn_q;
   assign wr0 = wb_valid_q & wb_wr0_q;

   // R0 side-port data takes priority over a plain WB write to register 0.
   function automatic logic [REG_FORWARD_WIDTH-1:0] fwd_sel(
      input logic                     use_i,
      input logic [REG_NUM_WIDTH-1:0] rn_i,
      input logic                     wr_i,
      input logic [REG_NUM_WIDTH-1:0] wrn_i,
      input logic                     wr0_i
   );
      if (!use_i)                 return REG_FORWARD_REG_FILE;
      else if (wr0_i && rn_i == '0) return REG_FORWARD_R0;
      else if (wr_i && wrn_i == rn_i) return REG_FORWARD_WB;
      else                        return REG_FORWARD_REG_FILE;
   endfunction

   assign reg_forward_1 = fwd_sel(id_use_1, id_rn_1, wr, wrn, wr0);
   assign reg_forward_2 = fwd_sel(id_use_2, id_rn_2, wr, wrn, wr0);

   assign haz_1 = id_valid & id_use_1 & ex_valid_q &
                  ((ex_wr_q & (ex_wrn_q == id_rn_1)) | (ex_wr0_q & (id_rn_1 == '0)));
   assign haz_2 = id_valid & id_use_2 & ex_valid_q &
                  ((ex_wr_q & (ex_wrn_q == id_rn_2)) | (ex_wr0_q & (id_rn_2 == '0)));
   assign busy  = (busy_cnt_q != '0);
   assign stall = haz_1 | haz_2 | busy;

   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_wr_d    = ex_wr_q;
      ex_wrn_d   = ex_wrn_q;
      ex_wr0_d   = ex_wr0_q;
      wb_valid_d = 1'b0;
      wb_wr_d    = wb_wr_q;
      wb_wrn_d   = wb_wrn_q;
      wb_wr0_d   = wb_wr0_q;
      busy_cnt_d = busy_cnt_q;
      if (busy) begin
         // Multi-cycle op keeps EX; WB sees bubbles until it completes.
         busy_cnt_d = busy_cnt_q - 1'b1;
      end else begin
         wb_valid_d = ex_valid_q;
         wb_wr_d    = ex_wr_q;
         wb_wrn_d   = ex_wrn_q;
         wb_wr0_d   = ex_wr0_q;
         if (stall || flush || !id_valid) begin
            ex_valid_d = 1'b0;
            ex_wr_d    = 1'b0;
            ex_wrn_d   = '0;
            ex_wr0_d   = 1'b0;
         end else begin
            ex_valid_d = 1'b1;
            ex_wr_d    = id_wr;
            ex_wrn_d   = id_wrn;
            ex_wr0_d   = id_wr0;
            if (id_multi)
               busy_cnt_d = CNT_W'(MULTI_CYCLES - 1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_wr_q    <= 1'b0;
         ex_wrn_q   <= '0;
         ex_wr0_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_wr_q    <= 1'b0;
         wb_wrn_q   <= '0;
         wb_wr0_q   <= 1'b0;
         busy_cnt_q <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_wr_q    <= ex_wr_d;
         ex_wrn_q   <= ex_wrn_d;
         ex_wr0_q   <= ex_wr0_d;
         wb_valid_q <= wb_valid_d;
         wb_wr_q    <= wb_wr_d;
         wb_wrn_q   <= wb_wrn_d;
         wb_wr0_q   <= wb_wr0_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

endmodule
